// File: rtl/spu_pkg.sv
// Shared types and helpers for the LayerNorm square-root scheduler and its sqrt unit.
package spu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Root width for a DW-bit operand; odd widths round up to the next even width.
  function automatic int rw_of(input int dw);
    return (dw + dw % 2) / 2;
  endfunction

endpackage

// File: rtl/spu_ln_sqrt.sv
// Iterative restoring integer square root: one result bit per cycle, finish pulse after RW cycles.
module spu_ln_sqrt
  import spu_pkg::*;
#(
  parameter  int DW = 16,
  localparam int RW = rw_of(DW)
) (
  input  logic          core_clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din_i,
  input  logic          din_valid_i,
  output logic          finish_o,
  output logic [RW-1:0] res_o
);

  localparam int CW = $clog2(RW + 1);

  logic [2*RW-1:0] r_x;
  logic [RW-1:0]   r_rem;
  logic [RW-1:0]   r_root;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_fin;

  logic [RW+1:0]   w_sh;
  logic [RW+1:0]   w_trial;
  logic            w_ge;

  assign w_sh    = {r_rem, r_x[2*RW-1 -: 2]};
  assign w_trial = {r_root, 2'b01};
  assign w_ge    = (w_sh >= w_trial);

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_fin  <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      if (din_valid_i) begin
        r_x    <= (2*RW)'(din_i);
        r_rem  <= '0;
        r_root <= '0;
        r_cnt  <= CW'(RW);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_x   <= r_x << 2;
        r_cnt <= r_cnt - 1'b1;
        if (w_ge) begin
          r_rem  <= RW'(w_sh - w_trial);
          r_root <= {r_root[RW-2:0], 1'b1};
        end else begin
          r_rem  <= RW'(w_sh);
          r_root <= {r_root[RW-2:0], 1'b0};
        end
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_fin  <= 1'b1;
        end
      end
    end
  end

  assign finish_o = r_fin;
  assign res_o    = r_root;

endmodule

// File: rtl/spu_rr_arb.sv
// Combinational round-robin pick: first asserted request at or above the pointer, wrapping.
module spu_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int             w_k;
  logic [IDW-1:0] w_sel;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = 0;
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_k   = (int'(i_ptr) + i) % NREQ;
      w_sel = IDW'(w_k);
      if (!o_any && i_req[w_sel]) begin
        o_any        = 1'b1;
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
      end
    end
  end

endmodule

// File: rtl/spu_ln_sqrt_sched.sv
// Shares one iterative sqrt unit between NREQ LayerNorm lanes with round-robin issue,
// a watchdog on the finish wait, and a single tagged valid/ready response channel.
module spu_ln_sqrt_sched
  import spu_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int DW   = 16,
  parameter  int TMO  = 12,
  localparam int RW   = rw_of(DW),
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               core_clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [DW-1:0]      sqrt_din_o,
  output logic               sqrt_din_valid_o,
  input  logic               sqrt_finish_i,
  input  logic [RW-1:0]      sqrt_res_i,
  output logic               rsp_valid_o,
  output logic [IDW-1:0]     rsp_id_o,
  output logic [RW-1:0]      rsp_data_o,
  output logic               rsp_err_o,
  input  logic               rsp_ready_i,
  output logic               busy_o
);

  localparam int            CW       = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [DW-1:0]  r_opnd;
  logic [RW-1:0]  r_data;
  logic           r_err;
  logic [CW-1:0]  r_cnt;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_tmo;
  logic [DW-1:0]   w_lane_data [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_lane
    assign w_lane_data[k] = req_data_i[k*DW +: DW];
  end

  spu_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_tmo = (r_cnt == TMO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (sqrt_finish_i || w_tmo) w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready_i) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_opnd <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any) begin
          r_opnd <= w_lane_data[w_idx];
          r_id   <= w_idx;
          r_ptr  <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
        end
        ST_ISSUE: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A finish in the expiry cycle still counts as a good result.
          if (sqrt_finish_i) begin
            r_data <= sqrt_res_i;
            r_err  <= 1'b0;
          end else if (w_tmo) begin
            r_data <= '0;
            r_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o      = (r_state == ST_IDLE) ? w_gnt : '0;
  assign sqrt_din_valid_o = (r_state == ST_ISSUE);
  assign sqrt_din_o       = (r_state == ST_ISSUE) ? r_opnd : '0;
  assign rsp_valid_o      = (r_state == ST_RESP);
  assign rsp_id_o         = (r_state == ST_RESP) ? r_id : '0;
  assign rsp_data_o       = (r_state == ST_RESP) ? r_data : '0;
  assign rsp_err_o        = (r_state == ST_RESP) ? r_err : 1'b0;
  assign busy_o           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spu_ln_sqrt_sched.sv
// Directed and randomized bench for spu_ln_sqrt_sched driving the real spu_ln_sqrt unit.
module tb_spu_ln_sqrt_sched;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int TMO  = 12;
  localparam int RW   = 8;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      sqrt_din;
  logic               sqrt_din_valid;
  logic               sqrt_finish;
  logic [RW-1:0]      sqrt_res;
  logic               unit_fin;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [RW-1:0]      rsp_data;
  logic               rsp_err;
  logic               rsp_ready;
  logic               busy;
  logic               suppress;
  logic               stray_fin;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int din_cnt = 0;
  logic [DW-1:0] last_din = '0;

  always #5 clk = ~clk;

  assign sqrt_finish = (unit_fin & ~suppress) | stray_fin;

  spu_ln_sqrt_sched #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
    .core_clk         (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .sqrt_din_o       (sqrt_din),
    .sqrt_din_valid_o (sqrt_din_valid),
    .sqrt_finish_i    (sqrt_finish),
    .sqrt_res_i       (sqrt_res),
    .rsp_valid_o      (rsp_valid),
    .rsp_id_o         (rsp_id),
    .rsp_data_o       (rsp_data),
    .rsp_err_o        (rsp_err),
    .rsp_ready_i      (rsp_ready),
    .busy_o           (busy)
  );

  spu_ln_sqrt #(.DW(DW)) u_sqrt (
    .core_clk    (clk),
    .rst_n       (rst_n),
    .din_i       (sqrt_din),
    .din_valid_i (sqrt_din_valid),
    .finish_o    (unit_fin),
    .res_o       (sqrt_res)
  );

  always @(negedge clk) begin
    if (sqrt_din_valid) begin
      din_cnt  = din_cnt + 1;
      last_din = sqrt_din;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int i = 0; i < NREQ; i++)
      if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge with requests driven; ends 1 unit into the next IDLE cycle.
  task automatic txn(input string tag, input int hold, input bit exp_err, input bit upd);
    int g, lat, d0, exp_lat;
    logic [DW-1:0]   op;
    logic [NREQ-1:0] exp_oh;
    logic [RW-1:0]   exp_data;
    g = pick(req_valid, ptr_m);
    exp_oh = (g < 0) ? '0 : (NREQ'(1) << g);
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_oh));
    if (g < 0) g = 0;
    op       = req_data[g*DW +: DW];
    exp_data = exp_err ? '0 : RW'(isqrt(int'(op)));
    exp_lat  = exp_err ? TMO + 2 : RW + 3;
    ptr_m    = (g + 1) % NREQ;
    d0       = din_cnt;
    step();
    lat = 1;
    if (upd) begin
      req_valid[g] = 1'($urandom_range(0, 1));
      req_data[g*DW +: DW] = DW'($urandom);
    end
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".id"}, 32'(rsp_id), 32'(g));
    chk({tag, ".data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, ".din_pulses"}, 32'(din_cnt - d0), 32'd1);
    chk({tag, ".din_data"}, 32'(last_din), 32'(op));
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_id"}, 32'(rsp_id), 32'(g));
      chk({tag, ".hold_data"}, 32'(rsp_data), 32'(exp_data));
      chk({tag, ".hold_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".hold_din"}, 32'(din_cnt - d0), 32'd1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_rsp"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int g;
    logic [15:0] lane_init [4];
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    suppress  = 1'b0;
    stray_fin = 1'b0;
    repeat (3) step();
    chk("reset.ready", 32'(req_ready), 32'd0);
    chk("reset.din_valid", 32'(sqrt_din_valid), 32'd0);
    chk("reset.din", 32'(sqrt_din), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_fields", {rsp_id, rsp_data, rsp_err}, 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // All lanes valid continuously: grants rotate 0,1,2,3,0.
    lane_init = '{16'd0, 16'd1, 16'd65535, 16'd100};
    for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = lane_init[k];
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) txn("rr_all", 0, 1'b0, 1'b0);

    // Lane 2 alone with 144.
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 16'd144;
    #1;
    chk("lane2.ready_now", 32'(req_ready), 32'b0100);
    txn("lane2", 0, 1'b0, 1'b0);

    // Response back-pressure.
    req_valid = 4'b1011;
    txn("backpress", 5, 1'b0, 1'b0);

    // Finish suppressed: watchdog expiry, then a normal transaction.
    suppress  = 1'b1;
    req_valid = 4'b0010;
    req_data[1*DW +: DW] = 16'd400;
    txn("timeout", 0, 1'b1, 1'b0);
    suppress = 1'b0;
    txn("after_tmo", 0, 1'b0, 1'b0);

    // Reset during WAIT.
    req_valid = 4'b0100;
    g = pick(req_valid, ptr_m);
    ptr_m = (g + 1) % NREQ;
    step();
    req_valid = '0;
    repeat (3) step();
    chk("rstwait.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait.busy", 32'(busy), 32'd0);
    chk("rstwait.outs", {req_ready, sqrt_din_valid, rsp_valid, rsp_err, rsp_id, rsp_data}, 32'd0);
    ptr_m = 0;
    step();
    rst_n = 1'b1;
    step();
    stray_fin = 1'b1;
    step();
    stray_fin = 1'b0;
    chk("stray.busy", 32'(busy), 32'd0);
    repeat (12) step();
    chk("stray.rsp", 32'(rsp_valid), 32'd0);
    req_valid = 4'hF;
    #1;
    chk("rstwait.ptr0", 32'(req_ready), 32'b0001);
    txn("post_rst", 0, 1'b0, 1'b0);

    // Pointer wrap: after lane 3, lanes 0 and 3 compete.
    req_valid = 4'b1000;
    txn("wrap_l3", 0, 1'b0, 1'b0);
    req_valid = 4'b1001;
    #1;
    chk("wrap.grant0", 32'(req_ready), 32'b0001);
    txn("wrap", 0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = DW'($urandom);
    req_valid = 4'(($urandom));
    for (int n = 0; n < 25; n++) begin
      if (req_valid == '0) begin
        g = $urandom_range(0, NREQ - 1);
        req_valid[g] = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) req_data[0 +: DW] = 16'hFFFF;
      txn("rnd", $urandom_range(0, 3), 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
